lamps_ctrl: RTL and testbench

Lamp/seven-segment display controller on the `lamps_export[41:0]` conduit of the `soc_calc` system. It drives six active-low 7-segment digits. Two requesters share the display: the HPS, through an Avalon-MM slave on the lightweight bridge, and the fabric calculator, through a valid/ready stream. Output updates are scheduled onto a refresh tick so the display never tears, and the controller adds optional blinking.

---
 rtl/lamps_pkg.sv | 34 +++
 rtl/lamps_hex7seg.sv | 36 +++
 rtl/lamps_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_lamps_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lamps_pkg.sv
// -----------------------------------------------------------------------------
// lamps_pkg
// Shared constants and types for the six-digit seven-segment lamp controller:
// Avalon register word addresses, CTRL bit positions, digit count, the
// all-segments-off pattern and the 6 x 7-bit frame type that maps digit i onto
// bits [7i+6:7i] of the lamp conduit.
// -----------------------------------------------------------------------------
package lamps_pkg;

    localparam int NUM_DIGITS = 6;
    localparam int SEG_W      = 7;

    // Active-low display: all ones means every segment is dark.
    localparam logic [SEG_W-1:0] LAMP_OFF = 7'h7F;

    // Avalon word addresses.
    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_VALUE  = 3'd1;
    localparam logic [2:0] ADDR_BLANK  = 3'd2;
    localparam logic [2:0] ADDR_RAW_LO = 3'd3;
    localparam logic [2:0] ADDR_RAW_HI = 3'd4;
    localparam logic [2:0] ADDR_STATUS = 3'd5;

    // CTRL register bit positions.
    localparam int CTRL_HPS_OWN  = 0;
    localparam int CTRL_BLINK_EN = 1;
    localparam int CTRL_RAW_MODE = 2;

    // Packed so that frame[i] lands on bits [7i+6:7i] of the flat output.
    typedef logic [NUM_DIGITS-1:0][SEG_W-1:0] frame_t;

    localparam frame_t FRAME_OFF = {NUM_DIGITS{LAMP_OFF}};

endpackage

// File: rtl/lamps_hex7seg.sv
// -----------------------------------------------------------------------------
// lamps_hex7seg
// Combinational hex-to-seven-segment decoder, active-high output.
//   nibble_i [3:0] : hex digit 0..F
//   seg_o    [6:0] : segments g..a (bit 0 = a), 1 = lit
// -----------------------------------------------------------------------------
module lamps_hex7seg (
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        // NOTE: a default on every path of a combinational block prevents a latch.
        seg_o = 7'h00;
        case (nibble_i)
            4'h0: seg_o = 7'h3F;
            4'h1: seg_o = 7'h06;
            4'h2: seg_o = 7'h5B;
            4'h3: seg_o = 7'h4F;
            4'h4: seg_o = 7'h66;
            4'h5: seg_o = 7'h6D;
            4'h6: seg_o = 7'h7D;
            4'h7: seg_o = 7'h07;
            4'h8: seg_o = 7'h7F;
            4'h9: seg_o = 7'h6F;
            4'hA: seg_o = 7'h77;
            4'hB: seg_o = 7'h7C;
            4'hC: seg_o = 7'h39;
            4'hD: seg_o = 7'h5E;
            4'hE: seg_o = 7'h79;
            4'hF: seg_o = 7'h71;
            default: seg_o = 7'h00;
        endcase
    end

endmodule

// File: rtl/lamps_ctrl.sv
// -----------------------------------------------------------------------------
// lamps_ctrl
// Six-digit active-low seven-segment controller shared by the HPS (Avalon-MM
// slave) and the fabric calculator (valid/ready stream). The displayed frame
// is only reloaded on a periodic refresh tick, so the display never tears;
// optional blinking blanks every other blink half-period.
//   clk_clk, reset_reset    : clock, synchronous active-high reset
//   avs_address/write/...   : Avalon-MM slave, no waitrequest, 1-cycle reads
//   calc_valid/ready/value/blank : calculator stream, VALUE/BLANK update
//   lamps_export [41:0]     : digit i at [7i+6:7i], segment a = bit 0, active-low
// -----------------------------------------------------------------------------
module lamps_ctrl
    import lamps_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_TICKS = 250
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic [2:0]  avs_address,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    input  logic        calc_valid,
    output logic        calc_ready,
    input  logic [23:0] calc_value,
    input  logic [5:0]  calc_blank,
    output logic [41:0] lamps_export
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = $clog2(BLINK_TICKS + 1);
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_TICKS - 1);

    // Register file
    logic [2:0]    ctrl_q,       ctrl_d;
    logic [23:0]   value_q,      value_d;
    logic [5:0]    blank_q,      blank_d;
    logic [20:0]   raw_lo_q,     raw_lo_d;
    logic [20:0]   raw_hi_q,     raw_hi_d;
    logic [15:0]   accept_cnt_q, accept_cnt_d;
    logic          pending_q,    pending_d;
    // Timing and output state
    logic [RW-1:0] refresh_cnt_q, refresh_cnt_d;
    logic [BW-1:0] blink_cnt_q,   blink_cnt_d;
    logic          phase_q,       phase_d;
    frame_t        lamps_q,       lamps_d;
    logic [31:0]   readdata_q,    readdata_d;

    logic   tick;
    logic   calc_xfer;
    logic   hps_hits_value;
    logic   pending_set;
    logic   blink_en;
    logic   raw_mode;
    frame_t hex_seg;
    frame_t raw_frame;
    frame_t frame_next;
    logic [31:0] rd_mux;

    // Only bits up to 23 of any register are implemented.
    logic unused_wdata;
    assign unused_wdata = ^avs_writedata[31:24];

    assign blink_en = ctrl_q[CTRL_BLINK_EN];
    assign raw_mode = ctrl_q[CTRL_RAW_MODE];
    assign tick     = (refresh_cnt_q == REFRESH_LAST);

    // HPS writes to VALUE/BLANK win over a same-cycle calc offer.
    assign hps_hits_value = avs_write &&
                            (avs_address == ADDR_VALUE || avs_address == ADDR_BLANK);
    assign calc_ready = !ctrl_q[CTRL_HPS_OWN] && !hps_hits_value;
    assign calc_xfer  = calc_valid && calc_ready;

    assign pending_set = (avs_write && avs_address <= ADDR_RAW_HI) || calc_xfer;

    // Hex decode of the current VALUE, one decoder per digit.
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_hex
        lamps_hex7seg u_hex (
            .nibble_i (value_q[4*g +: 4]),
            .seg_o    (hex_seg[g])
        );
    end

    assign raw_frame = {raw_hi_q, raw_lo_q};

    // Frame built from the registers as they stand before this edge's writes.
    always_comb begin
        frame_next = FRAME_OFF;
        if (blink_en && phase_q) begin
            frame_next = FRAME_OFF;
        end else if (raw_mode) begin
            frame_next = ~raw_frame;
        end else begin
            for (int d = 0; d < NUM_DIGITS; d++) begin
                frame_next[d] = blank_q[d] ? LAMP_OFF : ~hex_seg[d];
            end
        end
    end

    always_comb begin
        rd_mux = 32'h0;
        case (avs_address)
            ADDR_CTRL:   rd_mux = {29'h0, ctrl_q};
            ADDR_VALUE:  rd_mux = {8'h0, value_q};
            ADDR_BLANK:  rd_mux = {26'h0, blank_q};
            ADDR_RAW_LO: rd_mux = {11'h0, raw_lo_q};
            ADDR_RAW_HI: rd_mux = {11'h0, raw_hi_q};
            ADDR_STATUS: rd_mux = {14'h0, pending_q, phase_q, accept_cnt_q};
            default:     rd_mux = 32'h0;
        endcase
    end

    always_comb begin
        ctrl_d        = ctrl_q;
        value_d       = value_q;
        blank_d       = blank_q;
        raw_lo_d      = raw_lo_q;
        raw_hi_d      = raw_hi_q;
        accept_cnt_d  = accept_cnt_q;
        refresh_cnt_d = tick ? '0 : refresh_cnt_q + 1'b1;
        blink_cnt_d   = blink_cnt_q;
        phase_d       = phase_q;
        lamps_d       = tick ? frame_next : lamps_q;
        readdata_d    = avs_read ? rd_mux : readdata_q;

        if (avs_write) begin
            case (avs_address)
                ADDR_CTRL:   ctrl_d   = avs_writedata[2:0];
                ADDR_VALUE:  value_d  = avs_writedata[23:0];
                ADDR_BLANK:  blank_d  = avs_writedata[5:0];
                ADDR_RAW_LO: raw_lo_d = avs_writedata[20:0];
                ADDR_RAW_HI: raw_hi_d = avs_writedata[20:0];
                default:     ;
            endcase
        end

        // calc_ready already excludes an HPS write to VALUE/BLANK this cycle.
        if (calc_xfer) begin
            value_d      = calc_value;
            blank_d      = calc_blank;
            accept_cnt_d = accept_cnt_q + 16'd1;
        end

        // A set coinciding with the clearing tick must not be lost.
        pending_d = pending_set ? 1'b1 : (tick ? 1'b0 : pending_q);

        if (!blink_en) begin
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end else if (tick) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                phase_d     = !phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            // NOTE: there are no memories here, so every state register can take a reset value.
            ctrl_q        <= '0;
            value_q       <= '0;
            blank_q       <= '0;
            raw_lo_q      <= '0;
            raw_hi_q      <= '0;
            accept_cnt_q  <= '0;
            pending_q     <= 1'b0;
            refresh_cnt_q <= '0;
            blink_cnt_q   <= '0;
            phase_q       <= 1'b0;
            lamps_q       <= FRAME_OFF;
            readdata_q    <= '0;
        end else begin
            ctrl_q        <= ctrl_d;
            value_q       <= value_d;
            blank_q       <= blank_d;
            raw_lo_q      <= raw_lo_d;
            raw_hi_q      <= raw_hi_d;
            accept_cnt_q  <= accept_cnt_d;
            pending_q     <= pending_d;
            refresh_cnt_q <= refresh_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            phase_q       <= phase_d;
            lamps_q       <= lamps_d;
            readdata_q    <= readdata_d;
        end
    end

    assign lamps_export = lamps_q;
    assign avs_readdata = readdata_q;

endmodule

// File: tb/tb_lamps_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lamps_ctrl
// Directed scenarios followed by randomized traffic, all compared every cycle
// against a behavioural model of the register map, refresh and blink rules.
// -----------------------------------------------------------------------------
module tb_lamps_ctrl;

    localparam int REFRESH_DIV = 4;
    localparam int BLINK_TICKS = 2;

    localparam logic [6:0] HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
    localparam logic [41:0] ALL_OFF = 42'h3FF_FFFF_FFFF;

    logic        clk_clk;
    logic        reset_reset;
    logic [2:0]  avs_address;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic        calc_valid;
    logic        calc_ready;
    logic [23:0] calc_value;
    logic [5:0]  calc_blank;
    logic [41:0] lamps_export;

    lamps_ctrl #(
        .REFRESH_DIV (REFRESH_DIV),
        .BLINK_TICKS (BLINK_TICKS)
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset   (reset_reset),
        .avs_address   (avs_address),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_read      (avs_read),
        .avs_readdata  (avs_readdata),
        .calc_valid    (calc_valid),
        .calc_ready    (calc_ready),
        .calc_value    (calc_value),
        .calc_blank    (calc_blank),
        .lamps_export  (lamps_export)
    );

    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_known = 0;
    logic [2:0]  m_ctrl;
    logic [23:0] m_value;
    logic [5:0]  m_blank;
    logic [20:0] m_raw_lo, m_raw_hi;
    int          m_count;
    bit          m_pending;
    int          m_cycle;        // cycles since reset released
    int          m_blink_ticks;  // ticks seen while blink enabled
    logic [41:0] m_lamps;
    logic [31:0] m_rd;

    function automatic bit m_phase();
        return ((m_blink_ticks / BLINK_TICKS) % 2) == 1;
    endfunction

    function automatic bit exp_ready();
        return !m_ctrl[0] && !(avs_write && (avs_address == 3'd1 || avs_address == 3'd2));
    endfunction

    function automatic logic [41:0] model_frame();
        logic [41:0] f;
        logic [41:0] raw;
        raw = {m_raw_hi, m_raw_lo};
        for (int i = 0; i < 6; i++) begin
            if (m_ctrl[1] && m_phase())  f[7*i +: 7] = 7'h7F;
            else if (m_ctrl[2])          f[7*i +: 7] = ~raw[7*i +: 7];
            else if (m_blank[i])         f[7*i +: 7] = 7'h7F;
            else                         f[7*i +: 7] = ~HEX[m_value[4*i +: 4]];
        end
        return f;
    endfunction

    function automatic logic [31:0] model_read(input logic [2:0] a);
        case (a)
            3'd0: return {29'h0, m_ctrl};
            3'd1: return {8'h0, m_value};
            3'd2: return {26'h0, m_blank};
            3'd3: return {11'h0, m_raw_lo};
            3'd4: return {11'h0, m_raw_hi};
            3'd5: return {14'h0, m_pending, m_phase(), 16'(m_count)};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_edge();
        bit tick, xfer, set;
        if (reset_reset) begin
            m_known = 1; m_ctrl = 0; m_value = 0; m_blank = 0;
            m_raw_lo = 0; m_raw_hi = 0; m_count = 0; m_pending = 0;
            m_cycle = 0; m_blink_ticks = 0; m_lamps = ALL_OFF; m_rd = 0;
            return;
        end
        tick = (m_cycle % REFRESH_DIV) == REFRESH_DIV - 1;
        xfer = calc_valid && exp_ready();
        set  = (avs_write && avs_address <= 3'd4) || xfer;
        if (avs_read) m_rd = model_read(avs_address);
        if (tick) m_lamps = model_frame();
        m_pending = set ? 1'b1 : (tick ? 1'b0 : m_pending);
        if (!m_ctrl[1])  m_blink_ticks = 0;
        else if (tick)   m_blink_ticks++;
        if (avs_write) begin
            case (avs_address)
                3'd0: m_ctrl   = avs_writedata[2:0];
                3'd1: m_value  = avs_writedata[23:0];
                3'd2: m_blank  = avs_writedata[5:0];
                3'd3: m_raw_lo = avs_writedata[20:0];
                3'd4: m_raw_hi = avs_writedata[20:0];
                default: ;
            endcase
        end
        if (xfer) begin
            m_value = calc_value;
            m_blank = calc_blank;
            m_count = (m_count + 1) % 65536;
        end
        m_cycle++;
    endtask

    // One clock: inputs already driven after a negedge.
    task automatic run_cycle();
        #1;
        if (m_known) check("calc_ready", {63'h0, calc_ready}, {63'h0, exp_ready()});
        @(posedge clk_clk);
        model_edge();
        #1;
        check("lamps", {22'h0, lamps_export}, {22'h0, m_lamps});
        check("readdata", {32'h0, avs_readdata}, {32'h0, m_rd});
        @(negedge clk_clk);
    endtask

    task automatic clear_inputs();
        reset_reset = 0; avs_address = 0; avs_write = 0; avs_writedata = 0;
        avs_read = 0; calc_valid = 0; calc_value = 0; calc_blank = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    task automatic hps_write(input logic [2:0] a, input logic [31:0] d);
        avs_write = 1; avs_address = a; avs_writedata = d;
        run_cycle();
        avs_write = 0; avs_writedata = 0;
    endtask

    task automatic hps_read(input logic [2:0] a);
        avs_read = 1; avs_address = a;
        run_cycle();
        avs_read = 0;
    endtask

    initial begin
        int off_seen;
        int on_seen;
        clear_inputs();
        reset_reset = 1;
        @(negedge clk_clk);

        // 1: reset, then first tick shows all zeros
        run_cycle();
        check("reset_lamps", {22'h0, lamps_export}, {22'h0, ALL_OFF});
        check("reset_rdata", {32'h0, avs_readdata}, 64'h0);
        check("reset_ready", {63'h0, calc_ready}, 64'h1);
        reset_reset = 0;
        idle(3);
        check("pre_tick_off", {22'h0, lamps_export}, {22'h0, ALL_OFF});
        idle(1);
        check("first_tick", {22'h0, lamps_export}, {22'h0, {6{7'h40}}});

        // 2: VALUE=A5, pending before and after the tick
        hps_write(3'd1, 32'h0000_00A5);
        hps_read(3'd5);
        check("pending_set", {63'h0, avs_readdata[17]}, 64'h1);
        idle(4);
        hps_read(3'd5);
        check("pending_clr", {63'h0, avs_readdata[17]}, 64'h0);
        check("value_a5", {22'h0, lamps_export}, {22'h0, {4{7'h40}}, 7'h08, 7'h12});

        // 3: HPS wins a same-cycle conflict, calc completes next cycle
        calc_valid = 1; calc_value = 24'h123456; calc_blank = 6'h00;
        avs_write = 1; avs_address = 3'd1; avs_writedata = 32'h0;
        #1 check("conflict_ready", {63'h0, calc_ready}, 64'h0);
        run_cycle();
        avs_write = 0;
        run_cycle();
        calc_valid = 0;
        hps_read(3'd1);
        check("calc_value", {32'h0, avs_readdata}, 64'h123456);
        hps_read(3'd5);
        check("calc_count", {48'h0, avs_readdata[15:0]}, 64'h1);

        // 4: HPS ownership blocks the calculator
        hps_write(3'd0, 32'h1);
        for (int i = 0; i < 20; i++) begin
            calc_valid = 1; calc_value = 24'($urandom); calc_blank = 6'($urandom);
            #1 check("own_ready", {63'h0, calc_ready}, 64'h0);
            run_cycle();
        end
        calc_valid = 0;
        hps_read(3'd1);
        check("own_value", {32'h0, avs_readdata}, 64'h123456);
        hps_read(3'd5);
        check("own_count", {48'h0, avs_readdata[15:0]}, 64'h1);

        // 5: blinking alternates frame / all-off, clearing it steadies the frame
        hps_write(3'd0, 32'h2);
        off_seen = 0; on_seen = 0;
        for (int i = 0; i < 40; i++) begin
            run_cycle();
            if (lamps_export == ALL_OFF) off_seen++; else on_seen++;
        end
        check("blink_off_seen", {63'h0, off_seen > 0}, 64'h1);
        check("blink_on_seen", {63'h0, on_seen > 0}, 64'h1);
        hps_write(3'd0, 32'h0);
        idle(8);
        hps_read(3'd5);
        check("blink_phase0", {63'h0, avs_readdata[16]}, 64'h0);
        check("steady_frame", {22'h0, lamps_export},
              {22'h0, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02});

        // 6: raw mode, blanking, then reset mid-sequence
        hps_write(3'd0, 32'h4);
        hps_write(3'd3, 32'h7F);
        idle(5);
        check("raw_digit0", {22'h0, lamps_export}, {22'h0, {5{7'h7F}}, 7'h00});
        hps_write(3'd0, 32'h0);
        hps_write(3'd2, 32'h3F);
        idle(5);
        check("blank_all", {22'h0, lamps_export}, {22'h0, ALL_OFF});
        hps_write(3'd0, 32'h3);
        calc_valid = 1; reset_reset = 1;
        run_cycle();
        calc_valid = 0; reset_reset = 0;
        check("midreset_lamps", {22'h0, lamps_export}, {22'h0, ALL_OFF});
        for (int a = 0; a < 6; a++) begin
            hps_read(3'(a));
            check("midreset_reg", {32'h0, avs_readdata}, 64'h0);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            reset_reset   = ($urandom_range(0, 199) == 0);
            avs_write     = ($urandom_range(0, 3) == 0);
            avs_read      = ($urandom_range(0, 2) == 0);
            avs_address   = 3'($urandom_range(0, 7));
            avs_writedata = $urandom;
            calc_valid    = $urandom_range(0, 1) == 1;
            calc_value    = 24'($urandom);
            calc_blank    = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h0;
            run_cycle();
        end
        clear_inputs();
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
